// File: rtl/svi_lane_checker.sv
// svi_lane_checker
//   Samples three constant-valued interface lanes for a fixed window of
//   NSAMP cycles, counts lane A / lane B mismatches against their expected
//   constants (saturating), checks lane C for stability against its first
//   sample, then offers one summary report on a valid/ready handshake.
//
// Ports
//   clk, rst_n        : clock (rising edge), async active-low reset
//   i_start           : start a window (honoured only when idle)
//   i_a, i_b, i_c     : lanes under observation
//   o_busy            : high whenever a window or report is in progress
//   o_rpt_valid       : report available
//   i_rpt_ready       : report consumer ready; transfer on valid & ready
//   o_rpt_err_a/_b    : saturating mismatch counts for lanes A / B
//   o_rpt_c_first     : first lane C sample of the window
//   o_rpt_c_unstable  : a later lane C sample differed from the first
//   o_rpt_pass        : no errors on A/B and lane C stable
module svi_lane_checker #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] EXP_A = 8'h00,
  parameter logic [WIDTH-1:0] EXP_B = 8'hFF,
  parameter int               NSAMP = 4,
  parameter int               CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_c,
  output logic             o_busy,
  output logic             o_rpt_valid,
  input  logic             i_rpt_ready,
  output logic [CNT_W-1:0] o_rpt_err_a,
  output logic [CNT_W-1:0] o_rpt_err_b,
  output logic [WIDTH-1:0] o_rpt_c_first,
  output logic             o_rpt_c_unstable,
  output logic             o_rpt_pass
);

  localparam int             SCW      = $clog2(NSAMP + 1);
  // Last count value seen while still in SAMPLE; the increment on that
  // edge brings the counter to NSAMP as the FSM leaves SAMPLE.
  localparam logic [SCW-1:0] NSAMP_M1 = SCW'(NSAMP - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SAMPLE = 2'd1,
    S_DRAIN  = 2'd2,
    S_REPORT = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [SCW-1:0]   smp_cnt_q, smp_cnt_d;
  logic             cap_vld_q, cap_vld_d;
  logic [WIDTH-1:0] cap_a_q, cap_a_d;
  logic [WIDTH-1:0] cap_b_q, cap_b_d;
  logic [WIDTH-1:0] cap_c_q, cap_c_d;
  logic [CNT_W-1:0] err_a_q, err_a_d;
  logic [CNT_W-1:0] err_b_q, err_b_d;
  logic [WIDTH-1:0] c_first_q, c_first_d;
  logic             c_loaded_q, c_loaded_d;
  logic             c_unst_q, c_unst_d;
  logic             pass_q, pass_d;

  logic start_go;
  logic sampling;

  assign start_go = (state_q == S_IDLE) && i_start;
  assign sampling = (state_q == S_SAMPLE);

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (i_start) state_d = S_SAMPLE;
      S_SAMPLE: if (smp_cnt_q == NSAMP_M1) state_d = S_DRAIN;
      S_DRAIN:  state_d = S_REPORT;
      S_REPORT: if (i_rpt_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_busy      = (state_q != S_IDLE);
    o_rpt_valid = (state_q == S_REPORT);
  end

  // ---------------------------------------------------------------------
  // Capture stage: lanes registered every SAMPLE cycle; cap_vld marks the
  // cycle in which the compare stage should consume them.
  // ---------------------------------------------------------------------
  always_comb begin
    smp_cnt_d = smp_cnt_q;
    if (start_go)      smp_cnt_d = '0;
    else if (sampling) smp_cnt_d = smp_cnt_q + SCW'(1);

    cap_vld_d = sampling;
    cap_a_d   = sampling ? i_a : cap_a_q;
    cap_b_d   = sampling ? i_b : cap_b_q;
    cap_c_d   = sampling ? i_c : cap_c_q;
  end

  // ---------------------------------------------------------------------
  // Compare stage. The report fields are the accumulators themselves; they
  // are frozen outside the window, so they hold through REPORT and IDLE
  // until the next start clears them.
  // ---------------------------------------------------------------------
  always_comb begin
    err_a_d    = err_a_q;
    err_b_d    = err_b_q;
    c_first_d  = c_first_q;
    c_loaded_d = c_loaded_q;
    c_unst_d   = c_unst_q;

    if (start_go) begin
      err_a_d    = '0;
      err_b_d    = '0;
      c_first_d  = '0;
      c_loaded_d = 1'b0;
      c_unst_d   = 1'b0;
    end else if (cap_vld_q) begin
      if ((cap_a_q != EXP_A) && (err_a_q != '1)) err_a_d = err_a_q + CNT_W'(1);
      if ((cap_b_q != EXP_B) && (err_b_q != '1)) err_b_d = err_b_q + CNT_W'(1);
      if (!c_loaded_q) begin
        c_first_d  = cap_c_q;
        c_loaded_d = 1'b1;
      end else if (cap_c_q != c_first_q) begin
        c_unst_d = 1'b1;
      end
    end

    // Registered verdict computed from the same next-state values, so it
    // moves on the same edge as the counters it summarises.
    pass_d = (err_a_d == '0) && (err_b_d == '0) && !c_unst_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_cnt_q  <= '0;
      cap_vld_q  <= 1'b0;
      cap_a_q    <= '0;
      cap_b_q    <= '0;
      cap_c_q    <= '0;
      err_a_q    <= '0;
      err_b_q    <= '0;
      c_first_q  <= '0;
      c_loaded_q <= 1'b0;
      c_unst_q   <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      smp_cnt_q  <= smp_cnt_d;
      cap_vld_q  <= cap_vld_d;
      cap_a_q    <= cap_a_d;
      cap_b_q    <= cap_b_d;
      cap_c_q    <= cap_c_d;
      err_a_q    <= err_a_d;
      err_b_q    <= err_b_d;
      c_first_q  <= c_first_d;
      c_loaded_q <= c_loaded_d;
      c_unst_q   <= c_unst_d;
      pass_q     <= pass_d;
    end
  end

  assign o_rpt_err_a      = err_a_q;
  assign o_rpt_err_b      = err_b_q;
  assign o_rpt_c_first    = c_first_q;
  assign o_rpt_c_unstable = c_unst_q;
  assign o_rpt_pass       = pass_q;

endmodule

// File: tb/tb_svi_lane_checker.sv
// Directed bench for svi_lane_checker: one instance with default parameters
// (NSAMP=4, CNT_W=8) and one with NSAMP=6, CNT_W=2 for saturation and
// backpressure. Inputs change 1 time unit after a rising edge; outputs are
// checked at the same point.
module tb_svi_lane_checker;

  logic clk;
  logic rst_n;

  // instance 0: defaults
  logic       start0, ready0;
  logic [7:0] a0, b0, c0;
  logic       busy0, valid0, unst0, pass0;
  logic [7:0] erra0, errb0, cfirst0;

  // instance 1: NSAMP=6, CNT_W=2
  logic       start1, ready1;
  logic [7:0] a1, b1, c1;
  logic       busy1, valid1, unst1, pass1;
  logic [1:0] erra1, errb1;
  logic [7:0] cfirst1;

  int n_cmp = 0;
  int n_err = 0;

  svi_lane_checker u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_start(start0),
    .i_a(a0), .i_b(b0), .i_c(c0),
    .o_busy(busy0), .o_rpt_valid(valid0), .i_rpt_ready(ready0),
    .o_rpt_err_a(erra0), .o_rpt_err_b(errb0),
    .o_rpt_c_first(cfirst0), .o_rpt_c_unstable(unst0), .o_rpt_pass(pass0)
  );

  svi_lane_checker #(.NSAMP(6), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_start(start1),
    .i_a(a1), .i_b(b1), .i_c(c1),
    .o_busy(busy1), .o_rpt_valid(valid1), .i_rpt_ready(ready1),
    .o_rpt_err_a(erra1), .o_rpt_err_b(errb1),
    .o_rpt_c_first(cfirst1), .o_rpt_c_unstable(unst1), .o_rpt_pass(pass1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp_v);
    end
  endtask

  // Start a window on instance 0 and feed four samples; lists are written
  // in sample order (leftmost = first sample). Returns right after the
  // edge at which o_rpt_valid is expected to rise (k+5).
  task automatic run0(input string tag, input logic [3:0][7:0] av,
                      input logic [3:0][7:0] bv, input logic [3:0][7:0] cv);
    start0 = 1'b1;
    tick();                                  // edge k
    start0 = 1'b0;
    chk({tag, "_busy_k"}, 32'(busy0), 32'd1);
    for (int i = 3; i >= 0; i--) begin
      a0 = av[i]; b0 = bv[i]; c0 = cv[i];
      tick();                                // edges k+1..k+4
    end
    chk({tag, "_valid_k4"}, 32'(valid0), 32'd0);
    tick();                                  // edge k+5
    chk({tag, "_valid_k5"}, 32'(valid0), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    start0 = 1'b0; ready0 = 1'b0; a0 = 8'h00; b0 = 8'hFF; c0 = 8'h00;
    start1 = 1'b0; ready1 = 1'b0; a1 = 8'h00; b1 = 8'hFF; c1 = 8'h00;
    tick();
    tick();

    // ---- reset state ----
    chk("rst_busy",   32'(busy0),   32'd0);
    chk("rst_valid",  32'(valid0),  32'd0);
    chk("rst_err_a",  32'(erra0),   32'd0);
    chk("rst_err_b",  32'(errb0),   32'd0);
    chk("rst_cfirst", 32'(cfirst0), 32'd0);
    chk("rst_unst",   32'(unst0),   32'd0);
    chk("rst_pass",   32'(pass0),   32'd0);
    chk("rst_busy1",  32'(busy1),   32'd0);
    rst_n = 1'b1;

    // ---- nominal ----
    ready0 = 1'b1;
    run0("nom", {8'h00, 8'h00, 8'h00, 8'h00}, {8'hFF, 8'hFF, 8'hFF, 8'hFF},
         {8'h5A, 8'h5A, 8'h5A, 8'h5A});
    chk("nom_err_a",  32'(erra0),   32'd0);
    chk("nom_err_b",  32'(errb0),   32'd0);
    chk("nom_cfirst", 32'(cfirst0), 32'h5A);
    chk("nom_unst",   32'(unst0),   32'd0);
    chk("nom_pass",   32'(pass0),   32'd1);
    tick();                                  // transfer, one REPORT cycle
    chk("nom_valid_drop", 32'(valid0), 32'd0);
    chk("nom_busy_drop",  32'(busy0),  32'd0);

    // ---- lane A fault on samples 2 and 3 ----
    run0("fa", {8'h00, 8'h01, 8'h01, 8'h00}, {8'hFF, 8'hFF, 8'hFF, 8'hFF},
         {8'h5A, 8'h5A, 8'h5A, 8'h5A});
    chk("fa_err_a", 32'(erra0), 32'd2);
    chk("fa_err_b", 32'(errb0), 32'd0);
    chk("fa_pass",  32'(pass0), 32'd0);
    tick();
    chk("fa_valid_drop", 32'(valid0), 32'd0);
    chk("fa_hold_err_a", 32'(erra0),  32'd2);

    // ---- lane C instability ----
    run0("fc", {8'h00, 8'h00, 8'h00, 8'h00}, {8'hFF, 8'hFF, 8'hFF, 8'hFF},
         {8'h00, 8'h00, 8'h80, 8'h00});
    chk("fc_err_a",  32'(erra0),   32'd0);
    chk("fc_cfirst", 32'(cfirst0), 32'h00);
    chk("fc_unst",   32'(unst0),   32'd1);
    chk("fc_pass",   32'(pass0),   32'd0);
    tick();

    // ---- saturation + backpressure on instance 1 ----
    a1 = 8'h00; b1 = 8'h00; c1 = 8'h33; ready1 = 1'b0;
    start1 = 1'b1;
    tick();                                  // edge k
    for (int i = 0; i < 6; i++) begin
      start1 = (i == 1);                     // extra start while sampling
      tick();                                // edges k+1..k+6
    end
    start1 = 1'b0;
    chk("sat_valid_k6", 32'(valid1), 32'd0);
    tick();                                  // edge k+7
    chk("sat_valid_k7", 32'(valid1),  32'd1);
    chk("sat_err_b",    32'(errb1),   32'd3);
    chk("sat_err_a",    32'(erra1),   32'd0);
    chk("sat_cfirst",   32'(cfirst1), 32'h33);
    chk("sat_unst",     32'(unst1),   32'd0);
    chk("sat_pass",     32'(pass1),   32'd0);
    for (int i = 0; i < 10; i++) begin
      b1 = 8'(i);                            // lanes wiggle; report must not
      tick();
      chk("bp_valid",  32'(valid1),  32'd1);
      chk("bp_err_b",  32'(errb1),   32'd3);
      chk("bp_cfirst", 32'(cfirst1), 32'h33);
      chk("bp_pass",   32'(pass1),   32'd0);
    end
    ready1 = 1'b1;
    tick();
    chk("bp_xfer_valid", 32'(valid1), 32'd0);
    chk("bp_xfer_busy",  32'(busy1),  32'd0);
    ready1 = 1'b0;
    tick();
    chk("bp_no_queue", 32'(busy1), 32'd0);

    // ---- reset mid-window ----
    ready0 = 1'b1;
    start0 = 1'b1;
    tick();                                  // edge k
    start0 = 1'b0;
    a0 = 8'h01; b0 = 8'hFF; c0 = 8'h5A;
    tick();                                  // edge k+1: sample 1 captured
    tick();                                  // edge k+2: sample 1 compared
    chk("mid_err_a",  32'(erra0),   32'd1);
    chk("mid_cfirst", 32'(cfirst0), 32'h5A);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",   32'(busy0),   32'd0);
    chk("mid_rst_valid",  32'(valid0),  32'd0);
    chk("mid_rst_err_a",  32'(erra0),   32'd0);
    chk("mid_rst_cfirst", 32'(cfirst0), 32'd0);
    chk("mid_rst_pass",   32'(pass0),   32'd0);
    #2 rst_n = 1'b1;
    tick();
    chk("mid_idle_busy", 32'(busy0), 32'd0);
    run0("clean", {8'h00, 8'h00, 8'h00, 8'h00}, {8'hFF, 8'hFF, 8'hFF, 8'hFF},
         {8'hC3, 8'hC3, 8'hC3, 8'hC3});
    chk("clean_err_a",  32'(erra0),   32'd0);
    chk("clean_err_b",  32'(errb0),   32'd0);
    chk("clean_cfirst", 32'(cfirst0), 32'hC3);
    chk("clean_pass",   32'(pass0),   32'd1);
    tick();
    chk("clean_valid_drop", 32'(valid0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
